// File: rtl/vec9_stim.sv
// vec9_stim: pattern stimulus generator. It accepts one command (op, seed,
// len) and emits len+1 beats. Each beat is the previous beat transformed by
// op: shift left, logical shift right, arithmetic shift right or invert.
// Optional feature macro VEC9_STIM_PARITY_EN adds the out_parity output
// (XOR of out_data, qualified by out_valid).
module vec9_stim #(
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [3:0]       cmd_len,
  input  logic [WIDTH-1:0] cmd_seed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy
`ifdef VEC9_STIM_PARITY_EN
  ,
  output logic             out_parity
`endif
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [1:0]       op_q;
  logic [3:0]       cnt_q;   // beats remaining after the current one
  logic [WIDTH-1:0] data_q;
  logic             cmd_hs, out_hs;

  // One pattern step. Every result is exactly WIDTH bits wide, so it is
  // truncated by construction.
  function automatic logic [WIDTH-1:0] apply_op(input logic [1:0] op,
                                                input logic [WIDTH-1:0] v);
    case (op)
      2'b00:   apply_op = {v[WIDTH-2:0], 1'b0};
      2'b01:   apply_op = {1'b0, v[WIDTH-1:1]};
      2'b10:   apply_op = {v[WIDTH-1], v[WIDTH-1:1]};
      default: apply_op = ~v;
    endcase
  endfunction

  // State register; reset aborts any command in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and handshake outputs. These decode from state only, so
  // reset clears them without waiting for a clock.
  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nxt = RUN;
      end
      RUN: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        if (out_ready && cnt_q == 4'd0) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign cmd_hs   = cmd_valid & cmd_ready;
  assign out_hs   = out_valid & out_ready;
  assign out_last = out_valid & (cnt_q == 4'd0);
  assign out_data = data_q;

  // Datapath. A command load seeds the beat. Each accepted beat advances
  // the pattern and counts down. A stalled beat holds every register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= 2'b00;
      cnt_q  <= 4'd0;
      data_q <= '0;
    end else if (cmd_hs) begin
      op_q   <= cmd_op;
      cnt_q  <= cmd_len;
      data_q <= cmd_seed;
    end else if (out_hs) begin
      data_q <= apply_op(op_q, data_q);
      cnt_q  <= cnt_q - 4'd1;
    end
  end

`ifdef VEC9_STIM_PARITY_EN
  assign out_parity = out_valid & (^data_q);
`endif

endmodule

// File: doc/vec9_stim.md
VEC9_STIM -- requirements
Module: vec9_stim

Interface
REQ-001 SHALL provide parameter WIDTH, default 9, data path width in bits (legal range 2..32).
REQ-002 SHALL provide port clk, input, 1, the only clock; all state updates on its rising edge.
REQ-003 SHALL provide port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL provide port cmd_valid, input, 1, command present.
REQ-005 SHALL provide port cmd_ready, output, 1, command accepted when high with cmd_valid.
REQ-006 SHALL provide port cmd_op, input, 2, pattern operator.
REQ-007 SHALL provide port cmd_len, input, 4, beat count minus one (1..16 beats).
REQ-008 SHALL provide port cmd_seed, input, WIDTH, first beat value.
REQ-009 SHALL provide port out_valid, output, 1, out_data valid.
REQ-010 SHALL provide port out_ready, input, 1, downstream accepts the beat when high with out_valid.
REQ-011 SHALL provide port out_data, output, WIDTH, pattern beat.
REQ-012 SHALL provide port out_last, output, 1, final beat of the current command.
REQ-013 SHALL provide port busy, output, 1, high in every state except IDLE.

Function
REQ-014 SHALL implement the states IDLE and RUN only.
REQ-015 In IDLE: cmd_ready=1, out_valid=0; a handshake (cmd_valid & cmd_ready) at edge N captures op, seed and len, and enters RUN.
REQ-016 SHALL assert out_valid with out_data=seed in the cycle after edge N (one-cycle latency).
REQ-017 In RUN: cmd_ready=0; cmd_valid is ignored and no command is queued.
REQ-018 On each output handshake, out_data SHALL advance to op(out_data) and the remaining count SHALL decrement.
REQ-019 op 00 SHALL shift left by 1 with zero fill; the MSB is discarded.
REQ-020 op 01 SHALL shift right logically by 1 with zero fill.
REQ-021 op 10 SHALL shift right arithmetically by 1, replicating the MSB.
REQ-022 op 11 SHALL perform a bitwise invert.
REQ-023 All operator results SHALL be truncated to WIDTH bits.
REQ-024 out_last SHALL be 1 only while the remaining count is 0, i.e. on beat cmd_len+1.
REQ-025 A handshake on the last beat SHALL return the block to IDLE; cmd_ready rises the next cycle, so a new command's first beat is never emitted in the cycle immediately after a last beat.
REQ-026 While out_valid=1 and out_ready=0, out_data, out_last and out_valid SHALL hold stable.
REQ-027 cmd_len=0 SHALL produce exactly one beat, with out_last=1 on that beat.

Reset
REQ-028 rst_n low SHALL immediately force state=IDLE, out_valid=0, out_last=0, out_data=0, busy=0 and cmd_ready=1, regardless of clk.
REQ-029 Reset mid-command SHALL abort the command with no residual beats after release.
REQ-030 The first command SHALL be accepted on the first clk edge after rst_n rises.

Configuration
REQ-031 With macro VEC9_STIM_PARITY_EN defined, SHALL add output out_parity (1 bit), equal to the XOR of all out_data bits, qualified by out_valid and 0 in reset.
REQ-032 Without VEC9_STIM_PARITY_EN, the out_parity port and its logic SHALL be absent; all other behaviour is unchanged.

Verification
REQ-033 SHL walk: seed 9'h001, op 00, len 3, out_ready=1 -> beats 001, 002, 004, 008; out_last on the 4th beat; then IDLE.
REQ-034 ASHR fill: seed 9'h100, op 10, len 2 -> beats 100, 180, 1C0; out_last on 1C0.
REQ-035 Backpressure: seed 9'h0F0, op 11, len 1, out_ready low for 3 cycles -> 0F0 held 3 cycles, then 10F with out_last.
REQ-036 Ignored command: cmd_valid held high during RUN with seed 9'h1FF -> cmd_ready=0 throughout and no 1FF beat until IDLE is re-entered.
REQ-037 Reset abort: rst_n pulsed low during beat 2 of a len 5 command -> out_valid falls without a clock edge; no further beats; cmd_ready=1 after release.
REQ-038 Parity build: with VEC9_STIM_PARITY_EN, seed 9'h007, len 0 -> out_parity=1 and out_last=1.
